// File: rtl/psum_requant_if.sv
// rtl/psum_requant_if.sv - int8 result stream toward the output SRAM writer
interface psum_requant_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - accumulate PE partial sums, requantize to int8, buffer in a FIFO
module psum_requant #(
  parameter int ACC_LEN    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [31:0]        opsum,
  input  logic               psum_valid,
  input  logic [15:0]        scale,
  input  logic [4:0]         shift,
  input  logic               relu_en,
  psum_requant_if.master     res,
  output logic               overflow,
  output logic [7:0]         grp_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(ACC_LEN - 1);

  logic signed [31:0] acc;
  logic signed [31:0] s1_sum;
  logic               s1_vld;

  logic signed [48:0] prod;
  logic signed [49:0] bias;
  logic signed [49:0] rnd;
  logic [7:0]         q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;

  assign prod = 49'(s1_sum) * 49'($signed({1'b0, scale}));

  // Round half up before the arithmetic shift; bias is zero when shift is 0.
  always_comb begin
    bias = '0;
    if (shift != 5'd0) bias[shift - 5'd1] = 1'b1;
    rnd = ($signed({prod[48], prod}) + bias) >>> shift;
    if (relu_en && rnd[49])        q = 8'h00;
    else if (rnd > 50'sd127)       q = 8'h7f;
    else if (rnd < -50'sd128)      q = 8'h80;
    else                           q = rnd[7:0];
  end

  assign full          = count == (AW+1)'(FIFO_DEPTH);
  assign pop           = (count != '0) && res.out_ready;
  assign push          = s1_vld && (!full || pop);
  assign res.out_valid = count != '0;
  assign res.out_data  = res.out_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      grp_cnt  <= '0;
      s1_sum   <= '0;
      s1_vld   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      grp_cnt  <= '0;
      s1_vld   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (psum_valid) begin
        if (grp_cnt == LAST) begin
          s1_sum  <= acc + opsum;
          s1_vld  <= 1'b1;
          acc     <= '0;
          grp_cnt <= '0;
        end else begin
          acc     <= acc + opsum;
          grp_cnt <= grp_cnt + 8'd1;
          s1_vld  <= 1'b0;
        end
      end else begin
        s1_vld <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // No backpressure toward the PE: a result that cannot be stored is lost.
      if (s1_vld && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= q;
  end
endmodule
